// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands with write-back bypass, carries decode
// control into EX, and inserts load-use bubbles while stalling PC and IF/ID.
module id_ex_stage #(
    parameter int unsigned CTRL_W           = 8,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic [4:0]        ID_RN1,
    input  logic [4:0]        ID_RN2,
    input  logic              ID_Uses1,
    input  logic              ID_Uses2,
    input  logic [31:0]       ID_RD1,
    input  logic [31:0]       ID_RD2,
    input  logic [31:0]       ID_Imm,
    input  logic [4:0]        ID_WN,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WN,
    input  logic [31:0]       WB_WD,
    input  logic              Flush,
    input  logic              Hold,
    output logic              Stall_ID,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic [31:0]       EX_A,
    output logic [31:0]       EX_B,
    output logic [31:0]       EX_Imm,
    output logic [4:0]        EX_RN1,
    output logic [4:0]        EX_RN2,
    output logic [4:0]        EX_WN,
    output logic [CTRL_W-1:0] EX_Ctrl
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RN_W  = 5;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] BUBBLE_RELOAD = CNT_W'(LOAD_USE_BUBBLES - 1);

    typedef enum logic {IDLE, STALL} state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
        logic [RN_W-1:0]   rn1;
        logic [RN_W-1:0]   rn2;
        logic [RN_W-1:0]   wn;
    } ex_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    state_t           state;
    ex_t              ex_q;
    ex_t              ex_d;
    logic             hazard;
    logic             do_hold;
    logic             do_bubble;

    // r0 reads as zero; a same-cycle write-back to the read register overrides RF data
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [RN_W-1:0] rn,
        input logic [XLEN-1:0] rd,
        input logic            wb_we,
        input logic [RN_W-1:0] wb_wn,
        input logic [XLEN-1:0] wb_wd
    );
        logic [XLEN-1:0] res;
        res = rd;
        if (rn == '0)
            res = '0;
        else if (wb_we && (wb_wn != '0) && (wb_wn == rn))
            res = wb_wd;
        return res;
    endfunction

    assign state = (cnt == '0) ? IDLE : STALL;

    assign hazard = ID_Valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                    (ex_q.wn != '0) &&
                    ((ID_Uses1 && (ID_RN1 == ex_q.wn)) || (ID_Uses2 && (ID_RN2 == ex_q.wn)));

    always_comb begin
        ex_d           = '0;
        ex_d.valid     = 1'b1;
        ex_d.reg_write = ID_RegWrite;
        ex_d.mem_read  = ID_MemRead;
        ex_d.ctrl      = ID_Ctrl;
        ex_d.a         = sel_operand(ID_RN1, ID_RD1, WB_RegWrite, WB_WN, WB_WD);
        ex_d.b         = sel_operand(ID_RN2, ID_RD2, WB_RegWrite, WB_WN, WB_WD);
        ex_d.imm       = ID_Imm;
        ex_d.rn1       = ID_RN1;
        ex_d.rn2       = ID_RN2;
        ex_d.wn        = ID_WN;
    end

    // Next-state and stall decision, highest priority first
    always_comb begin
        cnt_next  = cnt;
        do_hold   = 1'b0;
        do_bubble = 1'b0;
        Stall_ID  = 1'b0;
        if (Flush) begin
            do_bubble = 1'b1;
            cnt_next  = '0;
        end else if (Hold) begin
            do_hold  = 1'b1;
            Stall_ID = 1'b1;
        end else if (state == STALL) begin
            do_bubble = 1'b1;
            cnt_next  = cnt - CNT_W'(1);
            Stall_ID  = 1'b1;
        end else if (hazard) begin
            do_bubble = 1'b1;
            cnt_next  = BUBBLE_RELOAD;
            Stall_ID  = 1'b1;
        end
        if (Reset)
            Stall_ID = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= '0;
            ex_q <= '0;
        end else begin
            cnt <= cnt_next;
            if (!do_hold) begin
                if (do_bubble || !ID_Valid)
                    ex_q <= '0;
                else
                    ex_q <= ex_d;
            end
        end
    end

    assign EX_Valid    = ex_q.valid;
    assign EX_RegWrite = ex_q.reg_write;
    assign EX_MemRead  = ex_q.mem_read;
    assign EX_Ctrl     = ex_q.ctrl;
    assign EX_A        = ex_q.a;
    assign EX_B        = ex_q.b;
    assign EX_Imm      = ex_q.imm;
    assign EX_RN1      = ex_q.rn1;
    assign EX_RN2      = ex_q.rn2;
    assign EX_WN       = ex_q.wn;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage register that sits directly downstream of the 32×32 register file. It captures the two read operands, applying a write-back bypass so a same-cycle register-file write is not missed. It also carries decode control into EX and generates the load-use interlock that stalls PC and IF/ID. It supports flush (taken branch) and hold (downstream wait).

## Interface
- CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1 with MEM→EX forwarding, 2 without); legal values 1..3
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- ID_Valid  in  1  ID holds a real instruction
- ID_RN1, ID_RN2  in  5  rs/rt numbers (same values driven to register-file read ports)
- ID_Uses1, ID_Uses2  in  1  instruction actually reads rs / rt
- ID_RD1, ID_RD2  in  32  register-file read data
- ID_Imm  in  32  sign/zero-extended immediate
- ID_WN  in  5  destination register
- ID_RegWrite, ID_MemRead  in  1  writes a register / is a load
- ID_Ctrl  in  CTRL_W  remaining control
- WB_RegWrite  in  1, WB_WN  in  5, WB_WD  in  32  write-back port (same signals as register-file write port)
- Flush  in  1  squash the ID instruction (taken branch resolved in EX)
- Hold  in  1  freeze the stage (downstream wait)
- Stall_ID  out  1  freeze PC and IF/ID this cycle
- EX_Valid, EX_RegWrite, EX_MemRead  out  1  registered
- EX_A, EX_B, EX_Imm  out  32  registered operands/immediate
- EX_RN1, EX_RN2, EX_WN  out  5  registered register numbers (for forwarding unit)
- EX_Ctrl  out  CTRL_W  registered

## Operation
- Operand select (combinational, before capture): A = 0 if ID_RN1==0; else WB_WD if WB_RegWrite && WB_WN!=0 && WB_WN==ID_RN1; else ID_RD1. B likewise with RN2/RD2.
- Hazard detect: HZ = ID_Valid && EX_Valid && EX_MemRead && EX_RegWrite && EX_WN!=0 && ((ID_Uses1 && ID_RN1==EX_WN) || (ID_Uses2 && ID_RN2==EX_WN)).
- Bubble counter Cnt (2 bits), states IDLE (Cnt==0) / STALL (Cnt!=0).
- Per-cycle action, priority order:
  - Flush: load bubble; Cnt←0; Stall_ID=0.
  - Hold: all EX_* and Cnt keep value; Stall_ID=1.
  - STALL: load bubble; Cnt←Cnt−1; Stall_ID=1.
  - IDLE && HZ: load bubble; Cnt←LOAD_USE_BUBBLES−1; Stall_ID=1.
  - else: load ID instruction (EX_Valid←ID_Valid, all fields captured); Stall_ID=0.
- Bubble: EX_Valid, EX_RegWrite, EX_MemRead, EX_Ctrl ← 0; data/number fields ← 0.
- ID_Valid=0 loads as a bubble (control forced 0) even when not flushing.
- Bypass applies on every capture, including the capture that ends a stall.

## Timing
- Reset (async): all EX_* = 0, Cnt = 0; Stall_ID = 0 while Reset asserted.
- Latency: ID inputs visible on EX_* one cycle after the capturing edge.
- Stall_ID is combinational from current inputs/state; valid same cycle as hazard.
- Load-use: instruction stalled exactly LOAD_USE_BUBBLES cycles, then enters EX.
- Hold mid-stall: Cnt frozen, stall count resumes after Hold drops; total bubbles unchanged.
- Flush and Hold together: Flush wins.
- Reset mid-stall: Cnt cleared immediately, no pending bubbles after release.
- WB bypass and HZ in same cycle: stall wins; the bypass is re-evaluated at the final capture.

## Test plan
- Reset with all inputs nonzero -> every EX_* = 0, Stall_ID = 0; first edge after release captures ID.
- ID_RN1=5, ID_RD1=0x11, WB_RegWrite=1, WB_WN=5, WB_WD=0xABCD -> EX_A=0xABCD next cycle; same with WB_WN=0 or ID_RN1=0 -> EX_A=0x11 / 0.
- Load r3 in EX, ID uses rt=r3 (LOAD_USE_BUBBLES=1) -> Stall_ID=1 one cycle, EX_Valid=0 one cycle, then instruction captured; ID_Uses2=0 -> no stall.
- LOAD_USE_BUBBLES=2, same hazard, Hold pulsed in 2nd stall cycle -> Stall_ID high 3 cycles, exactly 2 bubbles, EX_* frozen during Hold.
- Flush asserted during a stall -> EX_Valid=0, Cnt=0, Stall_ID=0 that cycle; Flush with Hold -> bubble loaded.
- Reset asserted mid-stall between edges -> EX_* = 0 and Stall_ID = 0 immediately, without waiting for an edge.
